time_adjuster: RTL and testbench

Multi-channel time-setting adjuster for the digital clock. It sits between the time-keeping counters and the display/memory path. Each cycle it passes the current field values through a register. A button press steps one field by ±1 with per-field modulus wrap-around. A held button auto-repeats after a programmable delay. A one-cycle strobe per field, plus a combined flag, tells the counter block to reload the adjusted value.

---
 rtl/time_adjuster.sv | 156 +++++++++++++++
 tb/tb_time_adjuster.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/time_adjuster.sv
// time_adjuster: per-field ±1 time-setting adjuster with auto-repeat.
// Registers the incoming field values each cycle. A button press (or an
// expiring repeat count) steps that field with modulus wrap-around. A one-cycle
// strobe tells the time-keeping counters to reload the adjusted value.
module time_adjuster #(
  parameter int                CH            = 3,
  parameter int                W             = 6,
  parameter logic [CH*W-1:0]   MODS          = {6'd24, 6'd60, 6'd60},
  parameter int                REPEAT_DELAY  = 500,
  parameter int                REPEAT_PERIOD = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [CH-1:0]     inc_i,
  input  logic [CH-1:0]     dec_i,
  input  logic [CH*W-1:0]   val_i,
  output logic [CH*W-1:0]   val_o,
  output logic [CH-1:0]     adj_o,
  output logic              flag_o
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  state_t        state_q [CH];
  logic [CW-1:0] cnt_q   [CH];

  // Previous effective request per channel. Both bits set only after reset,
  // which marks the channel as "held across reset" and blocks a press until
  // the button has been released once.
  logic [CH-1:0] up_q;
  logic [CH-1:0] dn_q;

  logic [CH-1:0]   req_up;
  logic [CH-1:0]   req_dn;
  logic [CH-1:0]   press;
  logic [CH-1:0]   fire;
  logic [CH*W-1:0] val_nxt;

  // Modulus of field k, widened by one bit so that 2^W (encoded as 0) fits.
  function automatic logic [W:0] mod_of(input int unsigned k);
    logic [W-1:0] raw;
    raw = MODS[k*W +: W];
    return (raw == '0) ? {1'b1, {W{1'b0}}} : {1'b0, raw};
  endfunction

  // Normalise an incoming value, then optionally step it by ±1 with wrap.
  function automatic logic [W-1:0] adjust(input logic [W-1:0] v, input logic [W:0] m,
                                          input logic do_step, input logic up);
    logic [W:0] n;
    n = ({1'b0, v} >= m) ? '0 : {1'b0, v};
    if (do_step) begin
      if (up) n = (n == m - 1'b1) ? '0 : n + 1'b1;
      else    n = (n == '0) ? m - 1'b1 : n - 1'b1;
    end
    return n[W-1:0];
  endfunction

  // Decode effective requests, press detection and whether each channel steps.
  always_comb begin
    req_up = '0;
    req_dn = '0;
    press  = '0;
    fire   = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      req_up[k] = inc_i[k] & ~dec_i[k];
      req_dn[k] = dec_i[k] & ~inc_i[k];
      press[k]  = (req_up[k] | req_dn[k]) && !(up_q[k] && dn_q[k]) &&
                  ((req_up[k] != up_q[k]) || (req_dn[k] != dn_q[k]));
      case (state_q[k])
        IDLE:    fire[k] = press[k];
        default: fire[k] = (req_up[k] | req_dn[k]) &&
                           (press[k] || (tick_i && (cnt_q[k] == CNT_ONE)));
      endcase
    end
  end

  // Next field values: normalised pass-through, stepped where a step fires.
  always_comb begin
    val_nxt = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      val_nxt[k*W +: W] = adjust(val_i[k*W +: W], mod_of(k), fire[k], req_up[k]);
    end
  end

  // Per-channel press/delay/repeat state machines and request history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_q <= '1;
      dn_q <= '1;
      for (int unsigned k = 0; k < CH; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      up_q <= req_up;
      dn_q <= req_dn;
      for (int unsigned k = 0; k < CH; k++) begin
        case (state_q[k])
          IDLE: begin
            if (press[k]) begin
              cnt_q[k]   <= DELAY_LD;
              state_q[k] <= DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (!(req_up[k] | req_dn[k])) begin
              cnt_q[k]   <= '0;
              state_q[k] <= IDLE;
            end else if (press[k]) begin
              // A direction swap restarts the full initial delay.
              cnt_q[k]   <= DELAY_LD;
              state_q[k] <= DELAY;
            end else if (tick_i) begin
              if (cnt_q[k] == CNT_ONE) begin
                cnt_q[k]   <= PERIOD_LD;
                state_q[k] <= REPEAT;
              end else begin
                cnt_q[k] <= cnt_q[k] - CNT_ONE;
              end
            end
          end
          default: begin
            cnt_q[k]   <= '0;
            state_q[k] <= IDLE;
          end
        endcase
      end
    end
  end

  // Registered outputs: adjusted values, per-field strobes and combined flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      val_o  <= '0;
      adj_o  <= '0;
      flag_o <= 1'b0;
    end else begin
      val_o  <= val_nxt;
      adj_o  <= fire;
      flag_o <= |fire;
    end
  end

endmodule

// File: tb/tb_time_adjuster.sv
// Directed testbench for time_adjuster: table of single-cycle vectors plus
// hand-written auto-repeat and reset-while-held sequences.
module tb_time_adjuster;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tick_i;
  logic [2:0]  inc_i;
  logic [2:0]  dec_i;
  logic [17:0] val_i;
  logic [17:0] val_o;
  logic [2:0]  adj_o;
  logic        flag_o;

  int n_tests = 0;
  int n_fail  = 0;

  time_adjuster #(
    .CH(3),
    .W(6),
    .MODS({6'd24, 6'd60, 6'd60}),
    .REPEAT_DELAY(3),
    .REPEAT_PERIOD(2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_i(tick_i),
    .inc_i (inc_i),
    .dec_i (dec_i),
    .val_i (val_i),
    .val_o (val_o),
    .adj_o (adj_o),
    .flag_o(flag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  inc;
    logic [2:0]  dec;
    logic [17:0] vin;
    logic [17:0] vexp;
    logic [2:0]  aexp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] pk(input int h, input int m, input int s);
    logic [5:0] hh, mm, ss;
    hh = 6'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  function automatic void add(input logic [2:0] inc, input logic [2:0] dec,
                              input logic [17:0] vin, input logic [17:0] vexp,
                              input logic [2:0] aexp);
    vec_t v;
    v.inc  = inc;
    v.dec  = dec;
    v.vin  = vin;
    v.vexp = vexp;
    v.aexp = aexp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [2:0] aexp;

    // Single-cycle vectors; state carries from one row to the next.
    add(3'b000, 3'b000, pk(5, 59, 59), pk(5, 59, 59), 3'b000);
    add(3'b000, 3'b000, pk(5, 59, 59), pk(5, 59, 59), 3'b000);
    add(3'b010, 3'b000, pk(5, 59, 59), pk(5, 0, 59),  3'b010);
    add(3'b000, 3'b000, pk(5, 59, 59), pk(5, 59, 59), 3'b000);
    add(3'b000, 3'b100, pk(0, 30, 10), pk(23, 30, 10), 3'b100);
    add(3'b000, 3'b000, pk(0, 30, 10), pk(0, 30, 10), 3'b000);
    add(3'b000, 3'b000, pk(0, 62, 10), pk(0, 0, 10),  3'b000);
    add(3'b001, 3'b001, pk(1, 2, 3),   pk(1, 2, 3),   3'b000);
    add(3'b001, 3'b000, pk(1, 2, 3),   pk(1, 2, 4),   3'b001);
    add(3'b001, 3'b000, pk(1, 2, 3),   pk(1, 2, 3),   3'b000);
    add(3'b000, 3'b001, pk(1, 2, 3),   pk(1, 2, 2),   3'b001);
    add(3'b000, 3'b000, pk(1, 2, 3),   pk(1, 2, 3),   3'b000);
    add(3'b011, 3'b100, pk(10, 20, 30), pk(9, 21, 31), 3'b111);
    add(3'b000, 3'b000, pk(10, 20, 30), pk(10, 20, 30), 3'b000);
    add(3'b001, 3'b000, pk(10, 20, 59), pk(10, 20, 0), 3'b001);
    add(3'b000, 3'b000, pk(10, 20, 59), pk(10, 20, 59), 3'b000);
    add(3'b000, 3'b010, pk(23, 0, 0),  pk(23, 59, 0), 3'b010);
    add(3'b000, 3'b000, pk(23, 0, 0),  pk(23, 0, 0),  3'b000);

    rst_i  = 1'b1;
    tick_i = 1'b0;
    inc_i  = '0;
    dec_i  = '0;
    val_i  = pk(5, 59, 59);
    cyc();
    cyc();
    chk("reset_val", 32'(val_o), 32'd0);
    chk("reset_adj", 32'(adj_o), 32'd0);
    chk("reset_flag", 32'(flag_o), 32'd0);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      inc_i = vecs[i].inc;
      dec_i = vecs[i].dec;
      val_i = vecs[i].vin;
      cyc();
      chk($sformatf("vec%0d_val", i), 32'(val_o), 32'(vecs[i].vexp));
      chk($sformatf("vec%0d_adj", i), 32'(adj_o), 32'(vecs[i].aexp));
      chk($sformatf("vec%0d_flag", i), 32'(flag_o), 32'(|vecs[i].aexp));
    end

    // Auto-repeat: delay 3 ticks, period 2 ticks, tick every 4 clocks.
    val_i  = pk(0, 0, 0);
    inc_i  = 3'b001;
    pulses = 0;
    cyc();
    chk("rep_press_adj", 32'(adj_o), 32'b001);
    chk("rep_press_val", 32'(val_o), 32'(pk(0, 0, 1)));
    if (adj_o[0]) pulses++;
    for (int t = 1; t <= 9; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick_i = (c == 3);
        cyc();
        aexp = (c == 3 && t >= 3 && (t % 2) == 1) ? 3'b001 : 3'b000;
        chk($sformatf("rep_t%0d_c%0d_adj", t, c), 32'(adj_o), 32'(aexp));
        if (adj_o[0]) pulses++;
      end
    end
    tick_i = 1'b0;
    chk("rep_pulse_count", 32'(pulses), 32'd5);
    inc_i = '0;
    cyc();
    chk("rep_release_adj", 32'(adj_o), 32'b000);
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
    chk("rep_idle_tick_adj", 32'(adj_o), 32'b000);

    // Reset pulse while inc_i[1] is held.
    val_i = pk(3, 7, 9);
    inc_i = 3'b010;
    cyc();
    chk("rst_held_press_adj", 32'(adj_o), 32'b010);
    chk("rst_held_press_val", 32'(val_o), 32'(pk(3, 8, 9)));
    cyc();
    chk("rst_held_hold_adj", 32'(adj_o), 32'b000);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_val", 32'(val_o), 32'd0);
    chk("rst_async_adj", 32'(adj_o), 32'd0);
    chk("rst_async_flag", 32'(flag_o), 32'd0);
    cyc();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rst_after_held%0d_adj", i), 32'(adj_o), 32'b000);
      chk($sformatf("rst_after_held%0d_val", i), 32'(val_o), 32'(pk(3, 7, 9)));
    end
    inc_i = '0;
    cyc();
    chk("rst_release_adj", 32'(adj_o), 32'b000);
    inc_i = 3'b010;
    cyc();
    chk("rst_repress_adj", 32'(adj_o), 32'b010);
    chk("rst_repress_val", 32'(val_o), 32'(pk(3, 8, 9)));
    chk("rst_repress_flag", 32'(flag_o), 32'd1);
    inc_i = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
